lag_pl_status_tracker: RTL and testbench
========================================

# lag_pl_status_tracker

Maintains the free/allocated status and downstream credit count of every output physical lane (PL) in a router, indexed [output port][PL]. Consumes the PL allocator's `pl_allocated` grants and the switch/link events (flit sent, tail sent, credit returned). Produces the `pl_status` vector the PL allocator reads to choose free PLs. A PL is returned to the free pool only after its tail flit has left and every downstream buffer slot has been credited back, which makes the unrestricted allocator's reallocation safe.

## Interface
- `np`, default 5: router ports.
- `nv`, default 4: PLs per port.
- `buf_len`, default 4: downstream buffer depth per PL, in flits. Must be ≥ 1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pl_allocated`  in  [np-1:0][nv-1:0]  allocator grant; marks the PL busy.
- `flit_sent`  in  [np-1:0][nv-1:0]  one flit left on this output PL this cycle.
- `tail_sent`  in  [np-1:0][nv-1:0]  the flit sent this cycle is a tail. Only meaningful with `flit_sent`.
- `credit_in`  in  [np-1:0][nv-1:0]  downstream returned one credit.
- `pl_status`  out  [np-1:0][nv-1:0]  1 = PL free and allocatable.
- `pl_can_send`  out  [np-1:0][nv-1:0]  PL is allocated, not draining, and credit > 0.
- `pl_credits`  out  [np-1:0][nv-1:0][CW-1:0]  current credit count, where CW = $clog2(buf_len+1).
- `pl_error`  out  1  sticky protocol-violation flag.

## Operation
Per-PL state: FREE, ALLOC, DRAIN. Credit counter range 0..buf_len.

Counter update, each cycle:
- `flit_sent` alone: count−1.
- `credit_in` alone: count+1.
- Both together: unchanged.
- `flit_sent` at count 0 without `credit_in` (underflow): counter holds, `pl_error` set.
- `credit_in` at count buf_len without `flit_sent` (overflow): counter holds, `pl_error` set.

State transitions:
- FREE → ALLOC on `pl_allocated`.
- ALLOC → DRAIN on `flit_sent && tail_sent`.
- DRAIN → FREE when the registered count == buf_len.
- Every other case: hold state.

Violations. Each sets `pl_error` and has no other effect:
- `pl_allocated` while not FREE.
- `flit_sent` while FREE or DRAIN.
- `tail_sent` without `flit_sent`.

Outputs:
- `pl_status` = (state == FREE).
- `pl_can_send` = (state == ALLOC) && count != 0.
- `pl_credits` = count.
- `pl_error` = OR of all PL violation events, registered and sticky until reset.

PLs are fully independent; no cross-PL arbitration happens inside this block.

## Timing
- Reset values: every state = FREE, every count = buf_len. Hence `pl_status` all 1s, `pl_can_send` all 0s, `pl_credits` all = buf_len, `pl_error` = 0.
- All outputs are registered state or a decode of registered state; no combinational path from inputs to outputs.
- `pl_allocated` at cycle t: `pl_status` = 0 from t+1 and `pl_can_send` = 1 from t+1 (count > 0).
- `flit_sent` at t: `pl_credits` updates at t+1.
- Tail sent at t: DRAIN at t+1.
- Final credit (count reaches buf_len) at t: count = buf_len at t+1, FREE at t+2. A PL therefore spends at least one cycle in DRAIN, even when credits are already full.
- A PL can be reallocated at the earliest the cycle after `pl_status` rises.
- Reset asserted mid-packet: state and counts return to reset values on the next edge. Any in-flight credits are discarded.

## Structure
- Shared package holds:
  - `pl_state_t` enum {FREE, ALLOC, DRAIN}.
  - Credit-width function `clog2`.
- Natural sub-module: `lag_pl_credit_fsm`, a single-PL state machine plus counter with a local error pulse output. Instantiated np×nv times in a generate loop.
- The top level only flattens the vectors and ORs the error pulses into the sticky `pl_error` register.

## Test plan
- Reset, buf_len=4 → all `pl_status` = 1, all `pl_credits` = 4, `pl_can_send` = 0, `pl_error` = 0.
- Allocate [2][1]; send 3 flits, tail on the third; no credits → `pl_credits` 4→1, DRAIN after tail, `pl_status` stays 0. Return 3 credits → count 4, then `pl_status` = 1 one cycle later.
- `flit_sent` and `credit_in` together on [0][0] at count 2 → count stays 2, no error.
- Send 4 flits with no credits on buf_len=4, then a 5th flit → count stays 0, `pl_can_send` = 0, `pl_error` = 1 and remains 1.
- `pl_allocated` on an already-allocated [1][3] → `pl_error` = 1; state and count of [1][3] unchanged.
- Assert reset mid-drain on [4][2] with count 1 → next cycle `pl_status` = 1, `pl_credits` = 4, `pl_error` = 0.

Source files
------------

// File: rtl/lag_pl_status_tracker_pkg.sv
// Shared types and helpers for the output physical-lane status tracker.
// Holds the per-lane state encoding and the credit-width function.
package lag_pl_status_tracker_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        ALLOC = 2'd1,
        DRAIN = 2'd2
    } pl_state_t;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lag_pl_credit_fsm.sv
// Single output PL: FREE/ALLOC/DRAIN state machine plus downstream credit counter.
// Raises a one-cycle err_pulse on any protocol violation seen by this PL.
module lag_pl_credit_fsm
    import lag_pl_status_tracker_pkg::*;
#(
    parameter int buf_len = 4,
    parameter int CW      = clog2(buf_len + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pl_allocated,
    input  logic          flit_sent,
    input  logic          tail_sent,
    input  logic          credit_in,
    output logic          pl_free,
    output logic          pl_can_send,
    output logic [CW-1:0] pl_credits,
    output logic          err_pulse
);

    localparam logic [CW-1:0] FULL = CW'(buf_len);

    pl_state_t     state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          flit_ok;
    logic          underflow, overflow;

    // Illegal events are flagged and otherwise ignored.
    assign flit_ok   = flit_sent && (state == ALLOC);
    assign underflow = flit_ok && !credit_in && (count == '0);
    assign overflow  = credit_in && !flit_ok && (count == FULL);

    assign err_pulse = (pl_allocated && (state != FREE))
                     | (flit_sent && (state != ALLOC))
                     | (tail_sent && !flit_sent)
                     | underflow
                     | overflow;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        count_nxt = count;
        state_nxt = state;
        if (flit_ok && !credit_in && !underflow) begin
            count_nxt = count - CW'(1);
        end else if (credit_in && !flit_ok && !overflow) begin
            count_nxt = count + CW'(1);
        end
        case (state)
            FREE:    if (pl_allocated)         state_nxt = ALLOC;
            ALLOC:   if (flit_ok && tail_sent) state_nxt = DRAIN;
            DRAIN:   if (count == FULL)        state_nxt = FREE;
            default:                           state_nxt = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state <= FREE;
            count <= FULL;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    assign pl_free     = (state == FREE);
    assign pl_can_send = (state == ALLOC) && (count != '0);
    assign pl_credits  = count;

endmodule

// File: rtl/lag_pl_status_tracker.sv
// Tracks free/allocated status and downstream credits for every output PL [port][PL].
// Instantiates one credit FSM per PL and folds their error pulses into a sticky flag.
module lag_pl_status_tracker
    import lag_pl_status_tracker_pkg::*;
#(
    parameter int np      = 5,
    parameter int nv      = 4,
    parameter int buf_len = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [np-1:0][nv-1:0]                       pl_allocated,
    input  logic [np-1:0][nv-1:0]                       flit_sent,
    input  logic [np-1:0][nv-1:0]                       tail_sent,
    input  logic [np-1:0][nv-1:0]                       credit_in,
    output logic [np-1:0][nv-1:0]                       pl_status,
    output logic [np-1:0][nv-1:0]                       pl_can_send,
    output logic [np-1:0][nv-1:0][clog2(buf_len+1)-1:0] pl_credits,
    output logic                                        pl_error
);

    localparam int CW = clog2(buf_len + 1);

    logic [np-1:0][nv-1:0] err_vec;

    for (genvar p = 0; p < np; p++) begin : g_port
        for (genvar v = 0; v < nv; v++) begin : g_pl
            lag_pl_credit_fsm #(
                .buf_len (buf_len),
                .CW      (CW)
            ) u_pl (
                .clk          (clk),
                .rst_n        (rst_n),
                .pl_allocated (pl_allocated[p][v]),
                .flit_sent    (flit_sent[p][v]),
                .tail_sent    (tail_sent[p][v]),
                .credit_in    (credit_in[p][v]),
                .pl_free      (pl_status[p][v]),
                .pl_can_send  (pl_can_send[p][v]),
                .pl_credits   (pl_credits[p][v]),
                .err_pulse    (err_vec[p][v])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pl_error <= 1'b0;
        end else if (|err_vec) begin
            pl_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lag_pl_status_tracker.sv
// Directed bench for lag_pl_status_tracker: expectations are queued as stimulus is
// driven and compared one cycle later against the registered outputs.
module tb_lag_pl_status_tracker;

    localparam int NP = 5;
    localparam int NV = 4;
    localparam int BL = 4;
    localparam int CW = 3;

    localparam int K_STATUS   = 0;
    localparam int K_CANSEND  = 1;
    localparam int K_CRED     = 2;
    localparam int K_ERR      = 3;
    localparam int K_STAT_VEC = 4;
    localparam int K_CAN_VEC  = 5;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic [NP-1:0][NV-1:0]           pl_allocated, flit_sent, tail_sent, credit_in;
    logic [NP-1:0][NV-1:0]           pl_status, pl_can_send;
    logic [NP-1:0][NV-1:0][CW-1:0]   pl_credits;
    logic                            pl_error;

    typedef struct {
        string       tag;
        int          kind;
        int          p;
        int          v;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    lag_pl_status_tracker #(.np(NP), .nv(NV), .buf_len(BL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pl_allocated (pl_allocated),
        .flit_sent    (flit_sent),
        .tail_sent    (tail_sent),
        .credit_in    (credit_in),
        .pl_status    (pl_status),
        .pl_can_send  (pl_can_send),
        .pl_credits   (pl_credits),
        .pl_error     (pl_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int kind, input int p, input int v);
        case (kind)
            K_STATUS:   return {31'b0, pl_status[p][v]};
            K_CANSEND:  return {31'b0, pl_can_send[p][v]};
            K_CRED:     return {29'b0, pl_credits[p][v]};
            K_ERR:      return {31'b0, pl_error};
            K_STAT_VEC: return {12'b0, pl_status};
            K_CAN_VEC:  return {12'b0, pl_can_send};
            default:    return 32'hdead_beef;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int kind, input int p, input int v,
                            input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.p = p; e.v = v; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_pl(input string tag, input int p, input int v,
                           input bit st, input bit cs, input int cred);
        push_exp({tag, ".status"},   K_STATUS,  p, v, {31'b0, st});
        push_exp({tag, ".can_send"}, K_CANSEND, p, v, {31'b0, cs});
        push_exp({tag, ".credits"},  K_CRED,    p, v, 32'(cred));
    endtask

    task automatic push_reset_state(input string tag);
        push_exp({tag, ".status_vec"}, K_STAT_VEC, 0, 0, 32'h000f_ffff);
        push_exp({tag, ".can_vec"},    K_CAN_VEC,  0, 0, 32'h0);
        push_exp({tag, ".error"},      K_ERR,      0, 0, 32'h0);
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++)
                push_exp($sformatf("%s.cred_%0d_%0d", tag, p, v), K_CRED, p, v, 32'(BL));
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind, e.p, e.v);
            n_tests++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // One clock edge; inputs driven before the call are consumed, then cleared.
    task automatic tick();
        @(posedge clk);
        #1;
        pl_allocated = '0;
        flit_sent    = '0;
        tail_sent    = '0;
        credit_in    = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        pl_allocated = '0;
        flit_sent    = '0;
        tail_sent    = '0;
        credit_in    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        push_reset_state("reset");
        check();

        // Allocate [2][1], send three flits with tail on the last, then refill credits.
        pl_allocated[2][1] = 1'b1; tick();
        push_pl("alloc21", 2, 1, 0, 1, 4); check();
        flit_sent[2][1] = 1'b1; tick();
        push_pl("f1_21", 2, 1, 0, 1, 3); check();
        flit_sent[2][1] = 1'b1; tick();
        push_pl("f2_21", 2, 1, 0, 1, 2); check();
        flit_sent[2][1] = 1'b1; tail_sent[2][1] = 1'b1; tick();
        push_pl("tail21", 2, 1, 0, 0, 1); check();
        credit_in[2][1] = 1'b1; tick();
        push_pl("c1_21", 2, 1, 0, 0, 2); check();
        credit_in[2][1] = 1'b1; tick();
        push_pl("c2_21", 2, 1, 0, 0, 3); check();
        credit_in[2][1] = 1'b1; tick();
        push_pl("c3_21", 2, 1, 0, 0, 4); check();
        tick();
        push_pl("free21", 2, 1, 1, 0, 4);
        push_exp("err_after_drain", K_ERR, 0, 0, 32'h0); check();
        pl_allocated[2][1] = 1'b1; tick();
        push_pl("realloc21", 2, 1, 0, 1, 4); check();

        // Simultaneous flit and credit on [0][0] at count 2.
        pl_allocated[0][0] = 1'b1; tick();
        flit_sent[0][0] = 1'b1; tick();
        flit_sent[0][0] = 1'b1; tick();
        push_pl("pre_both00", 0, 0, 0, 1, 2); check();
        flit_sent[0][0] = 1'b1; credit_in[0][0] = 1'b1; tick();
        push_pl("both00", 0, 0, 0, 1, 2);
        push_exp("both00.err", K_ERR, 0, 0, 32'h0); check();

        // Exhaust credits on [3][0], then underflow.
        pl_allocated[3][0] = 1'b1; tick();
        for (int i = 0; i < BL; i++) begin
            flit_sent[3][0] = 1'b1; tick();
        end
        push_pl("empty30", 3, 0, 0, 0, 0);
        push_exp("empty30.err", K_ERR, 0, 0, 32'h0); check();
        flit_sent[3][0] = 1'b1; tick();
        push_pl("under30", 3, 0, 0, 0, 0);
        push_exp("under30.err", K_ERR, 0, 0, 32'h1); check();
        tick(); tick();
        push_exp("err_sticky", K_ERR, 0, 0, 32'h1); check();

        // Credit overflow on an idle, full PL [4][0].
        do_reset();
        push_reset_state("reset2"); check();
        credit_in[4][0] = 1'b1; tick();
        push_pl("over40", 4, 0, 1, 0, 4);
        push_exp("over40.err", K_ERR, 0, 0, 32'h1); check();

        // Re-allocating a busy PL [1][3].
        do_reset();
        push_exp("reset3.err", K_ERR, 0, 0, 32'h0); check();
        pl_allocated[1][3] = 1'b1; tick();
        flit_sent[1][3] = 1'b1; tick();
        push_pl("pre_dup13", 1, 3, 0, 1, 3);
        push_exp("pre_dup13.err", K_ERR, 0, 0, 32'h0); check();
        pl_allocated[1][3] = 1'b1; tick();
        push_pl("dup13", 1, 3, 0, 1, 3);
        push_exp("dup13.err", K_ERR, 0, 0, 32'h1); check();

        // Reset in the middle of draining [4][2] at count 1.
        pl_allocated[4][2] = 1'b1; tick();
        flit_sent[4][2] = 1'b1; tick();
        flit_sent[4][2] = 1'b1; tick();
        flit_sent[4][2] = 1'b1; tail_sent[4][2] = 1'b1; tick();
        push_pl("drain42", 4, 2, 0, 0, 1); check();
        do_reset();
        push_reset_state("reset_mid"); check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
